// File: rtl/ascii_uart_pkg.sv
// Shared definitions for the ASCII UART transmitter.
//   state_e            : transmitter FSM state encoding
//   AsciiQmark         : character sent in place of a byte flagged as an error
//   DefaultClksPerBit  : default clk cycles per serial bit
package ascii_uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } state_e;

  localparam logic [7:0] AsciiQmark = 8'h3F;

  localparam int unsigned DefaultClksPerBit = 16;

endpackage

// File: rtl/ascii_uart_tx_sync_fifo.sv
// Synchronous FIFO with show-ahead output.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, empties the FIFO
//   push  : write din (ignored when full)
//   pop   : drop the head entry (ignored when empty)
//   din   : write data
//   dout  : head entry, valid whenever empty is low
//   full  : no free entry
//   empty : no stored entry
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ascii_uart_tx.sv
// UART 8N1 transmitter for the BCD-to-ASCII converter output.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset, aborts any frame in progress
//   in_valid : in_data/in_err hold a character
//   in_ready : character buffer can accept this cycle
//   in_data  : ASCII character
//   in_err   : when set, '?' is queued instead of in_data
//   tx       : registered serial line, idles high
//   busy     : a frame is in progress or characters are queued
module ascii_uart_tx
  import ascii_uart_pkg::*;
#(
  parameter int unsigned M            = 8,
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_data,
  input  logic         in_err,
  output logic         tx,
  output logic         busy
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW  = (M > 1) ? $clog2(M) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(M - 1);

  state_e            state_q, state_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [M-1:0]      shift_q, shift_d;
  logic              tx_q, tx_d;

  logic              fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [M-1:0]      fifo_din, fifo_dout;
  logic              baud_wrap;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full;
  assign fifo_din  = in_err ? M'(AsciiQmark) : in_data;
  assign baud_wrap = (baud_q == BaudLast);
  assign tx        = tx_q;
  assign busy      = (state_q != StIdle) || !fifo_empty;

  sync_fifo #(
    .WIDTH (M),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // tx_d is derived alongside state_d so the registered line changes on the same
  // edge as the state it belongs to.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = '0;
          state_d  = StStart;
          tx_d     = 1'b0;
        end
      end
      StStart: begin
        if (baud_wrap) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == BitLast) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + BitW'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StStop: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (!fifo_empty) begin
            // Back-to-back frame: no idle cycle after the stop bit.
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = StStart;
            tx_d     = 1'b0;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_ascii_uart_tx.sv
// Directed bench for ascii_uart_tx: a scoreboard queue holds the bytes expected
// on the line, and a frame decoder checks every tx cycle of each frame.
module tb_ascii_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_err = 1'b0;
  logic       tx;
  logic       busy;

  ascii_uart_tx #(
    .M            (8),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_err   (in_err),
    .tx       (tx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Scoreboard and frame decoder.
  logic [7:0] sb_q [$];
  int         start_cyc [$];
  int         frames_started = 0;
  int         frames_done = 0;
  logic [9:0] mon_frame;
  int         mon_cnt = 0;
  bit         mon_active = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
    end else if (mon_active) begin
      chk1("tx_bit", tx, mon_frame[mon_cnt / CPB]);
      mon_cnt++;
      if (mon_cnt == 10 * CPB) begin
        mon_active = 1'b0;
        frames_done++;
      end
    end else if (tx === 1'b0) begin
      logic       has;
      logic [7:0] b;
      has = (sb_q.size() > 0);
      chk1("sb_has_entry", has, 1'b1);
      b = has ? sb_q.pop_front() : 8'h00;
      frames_started++;
      start_cyc.push_back(cyc);
      mon_frame  = {1'b1, b, 1'b0};
      mon_cnt    = 1;
      mon_active = 1'b1;
    end
  end

  // Present a character and hold it until accepted; acc is the cycle count just
  // before the accepting edge.
  task automatic send(input logic [7:0] d, input logic e, output int acc);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_err   = e;
    while (!in_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk1("send_ready", in_ready, 1'b1);
    acc = cyc;
    sb_q.push_back(e ? 8'h3F : d);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (frames_done < target && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("frames_done", frames_done, target);
  endtask

  task automatic wait_started(input int target);
    int n;
    n = 0;
    while (frames_started < target && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("frames_started", frames_started, target);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int acc, base, sidx, s1, n_acc, fs;
    int accs [6];

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_tx", tx, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ready", in_ready, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: 'A' frame, start latency and busy release.
    base = frames_done;
    sidx = frames_started;
    send(8'h41, 1'b0, acc);
    idle();
    chk1("t1_busy_queued", busy, 1'b1);
    wait_started(sidx + 1);
    chk("t1_latency", start_cyc[sidx] - acc, 2);
    wait_cyc(start_cyc[sidx] + 39);
    chk1("t1_busy_stop", busy, 1'b1);
    chk1("t1_tx_stop", tx, 1'b1);
    wait_done(base + 1);
    wait_cyc(start_cyc[sidx] + 40);
    chk1("t1_busy_end", busy, 1'b0);
    chk1("t1_tx_end", tx, 1'b1);

    // 2: error flag substitutes '?'.
    base = frames_done;
    send(8'h37, 1'b1, acc);
    idle();
    wait_done(base + 1);

    // 3: six back-to-back pushes.
    base = frames_done;
    for (int i = 0; i < 6; i++) begin
      send(8'h61 + 8'(i), 1'b0, acc);
      accs[i] = acc;
    end
    idle();
    for (int i = 1; i < 5; i++) chk("t3_burst_acc", accs[i] - accs[0], i);
    chk("t3_sixth_acc", accs[5] - accs[0], 42);
    wait_done(base + 6);
    wait_cyc(cyc + 2);
    chk1("t3_busy_end", busy, 1'b0);

    // 4: two frames with no gap.
    base = frames_done;
    sidx = frames_started;
    send(8'h30, 1'b0, acc);
    send(8'h31, 1'b0, acc);
    idle();
    wait_done(base + 2);
    s1 = start_cyc[sidx];
    chk("t4_gap", start_cyc[sidx + 1] - s1, 40);
    wait_cyc(s1 + 80);
    chk1("t4_tx_idle", tx, 1'b1);
    chk1("t4_busy_idle", busy, 1'b0);

    // 5: reset mid-DATA with two characters queued.
    sidx = frames_started;
    send(8'h51, 1'b0, acc);
    send(8'h52, 1'b0, acc);
    send(8'h53, 1'b0, acc);
    idle();
    wait_started(sidx + 1);
    wait_cyc(start_cyc[sidx] + CPB + 10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk1("t5_tx", tx, 1'b1);
    chk1("t5_busy", busy, 1'b0);
    chk1("t5_ready", in_ready, 1'b1);
    sb_q.delete();
    fs = frames_started;
    repeat (100) begin
      @(posedge clk); #1;
    end
    chk("t5_no_frames", frames_started, fs);
    chk1("t5_tx_after", tx, 1'b1);
    chk1("t5_busy_after", busy, 1'b0);

    // 6: in_valid held with changing data while the buffer is full.
    base = frames_done;
    for (int i = 0; i < 5; i++) send(8'h70 + 8'(i), 1'b0, acc);
    chk1("t6_full", in_ready, 1'b0);
    n_acc = 0;
    for (int i = 0; i < 60; i++) begin
      in_valid = 1'b1;
      in_err   = 1'b0;
      in_data  = 8'($urandom_range(32, 126));
      if (in_ready) begin
        sb_q.push_back(in_data);
        n_acc++;
      end
      @(posedge clk); #1;
    end
    idle();
    chk("t6_accepts", n_acc, 1);
    wait_done(base + 5 + n_acc);
    wait_cyc(cyc + 50);
    chk("t6_no_extra", frames_started - fs, 5 + n_acc);
    chk("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
